rr_stream_mux: RTL
==================

// Module: rr_stream_mux
//
// PURPOSE
//  N-to-1 valid/ready stream multiplexer with round-robin arbitration, optional burst locking and a
//  registered output stage. Sits between several request producers (e.g. issue/LSU/fetch ports)
//  and a single shared consumer (memory or bus port). One beat per cycle sustained throughput.
//
// PARAMETERS
//  NUM_REQ     4   number of input channels (>= 2; need not be a power of 2)
//  DATA_WIDTH  64  payload width per beat
//  MAX_BURST   1   max consecutive beats a winner may hold the grant (>= 1; 1 = pure round robin)
//
// PORTS
//  clk_i        in   1                     clock, rising edge
//  arst_ni      in   1                     asynchronous reset, active low
//  flush_i      in   1                     synchronous flush of output stage and burst lock
//  in_data_i    in   NUM_REQ x DATA_WIDTH  per-channel payload, [NUM_REQ-1:0][DATA_WIDTH-1:0]
//  in_valid_i   in   NUM_REQ               per-channel valid
//  in_ready_o   out  NUM_REQ               per-channel ready, one-hot or zero
//  out_data_o   out  DATA_WIDTH            registered payload
//  out_index_o  out  $clog2(NUM_REQ)       channel the current out beat came from
//  out_valid_o  out  1                     registered valid
//  out_ready_i  in   1                     consumer ready
//
// BEHAVIOUR
//  - Reset (arst_ni=0, async): out_valid_o=0, out_data_o=0, out_index_o=0, ptr=0, state=ARB,
//    cnt=0, in_ready_o=0 (gated combinationally by arst_ni). In-flight out beat discarded.
//  - accept = ~out_valid_o | out_ready_i. in_ready_o[k] = accept & ~flush_i & gnt[k].
//    Input transfer on channel k: in_valid_i[k] & in_ready_o[k]. Producers must not make valid
//    depend on ready; in_ready_o may depend combinationally on in_valid_i and out_ready_i.
//  - Output register: on input transfer load data/index, out_valid_o=1 next edge (latency 1).
//    Else if out_valid_o & out_ready_i, out_valid_o<=0. out_data_o/out_index_o stable while
//    out_valid_o & ~out_ready_i. Drain and load in same cycle -> back-to-back beats, no bubble.
//  - Round-robin grant: among valid channels, first found searching ptr, ptr+1, ... mod NUM_REQ.
//    ptr, owner: $clog2(NUM_REQ) bits; wrap NUM_REQ-1 -> 0 explicitly (non-pow2 safe).
//  - FSM states ARB, HOLD; cnt is $clog2(MAX_BURST+1) bits.
//    ARB: grant by round robin. Transfer from k: if MAX_BURST==1 -> ptr<=k+1, stay ARB;
//      else owner<=k, cnt<=1, -> HOLD.
//    HOLD, accept=1, in_valid_i[owner]=1: grant owner only. On transfer cnt<=cnt+1; if
//      cnt+1==MAX_BURST -> ptr<=owner+1, cnt<=0, -> ARB.
//    HOLD, accept=1, in_valid_i[owner]=0: burst ends this cycle; grant by round robin from
//      owner+1 same cycle, transfer handled as in ARB; ptr<=owner+1 if no transfer.
//  - accept=0 (stall): no grants; state, ptr, owner, cnt hold. Valid drops during stall ignored.
//  - No valid inputs: no grant, no state change.
//  - flush_i=1 (priority over all except reset): in_ready_o=0, out_valid_o<=0 next edge,
//    state<=ARB, cnt<=0, ptr unchanged.
//
// TESTING
//  1 Reset held, in_valid_i=4'hF -> in_ready_o=0, out_valid_o=0; release, out_ready_i=1 ->
//    grants 0,1,2,3,0 on consecutive cycles, out_index_o same sequence one cycle later.
//  2 Beat from ch2 data 0xA5, then out_ready_i=0 for 5 cycles, all valid -> out_data_o holds
//    0xA5, in_ready_o=0 throughout; release -> next grant ch3.
//  3 MAX_BURST=4, in_valid_i=4'b0011 steady, out_ready_i=1 -> grants 0,0,0,0,1,1,1,1,0.
//  4 MAX_BURST=4, owner ch1 drops valid after 2 beats, ch0 and ch3 valid -> ch3 granted same
//    cycle, then ch3 holds up to 4 beats.
//  5 NUM_REQ=3, all valid -> 0,1,2,0 wrap; only ch2 valid -> ch2 granted every cycle, no bubble.
//  6 out_valid_o=1, flush_i pulse with in_valid_i=4'hF -> no input transfer that cycle,
//    out_valid_o=0 next cycle, following grant starts from unchanged ptr.

Source files
------------

// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream mux with round-robin arbitration,
// optional burst locking and a registered output stage.
module rr_stream_mux #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 1
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic                                 flush_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   in_data_i,
  input  logic [NUM_REQ-1:0]                   in_valid_i,
  output logic [NUM_REQ-1:0]                   in_ready_o,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic [$clog2(NUM_REQ)-1:0]           out_index_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB,
    HOLD
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;

  logic [DATA_WIDTH-1:0] data_q;
  logic [IW-1:0]         index_q;
  logic                  valid_q;

  logic          accept;
  logic          hold_ok;
  logic [IW-1:0] rr_start;
  logic [IW-1:0] rr_idx;
  logic          rr_found;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] gnt_idx;
  logic          gnt_any;
  logic          xfer;

  // Explicit wrap keeps non-power-of-two channel counts correct.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] x);
    if (x == IW'(NUM_REQ - 1)) return '0;
    return x + 1'b1;
  endfunction

  assign accept  = ~valid_q | out_ready_i;
  assign hold_ok = (state_q == HOLD) & in_valid_i[owner_q];
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    rr_start = (state_q == HOLD) ? wrap_inc(owner_q) : ptr_q;
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_start} + (IW+1)'(i);
      if (rr_sum >= (IW+1)'(NUM_REQ))
        rr_sum = rr_sum - (IW+1)'(NUM_REQ);
      if (!rr_found && in_valid_i[rr_sum[IW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_sum[IW-1:0];
      end
    end
  end

  assign gnt_idx = hold_ok ? owner_q : rr_idx;
  assign gnt_any = hold_ok | rr_found;
  assign xfer    = arst_ni & accept & ~flush_i & gnt_any;

  always_comb begin
    in_ready_o = '0;
    if (xfer) in_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = ARB;
      cnt_d   = '0;
    end else if (accept) begin
      if (hold_ok) begin
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(MAX_BURST)) begin
          ptr_d   = wrap_inc(owner_q);
          cnt_d   = '0;
          state_d = ARB;
        end
      end else if (xfer) begin
        if (MAX_BURST == 1) begin
          ptr_d = wrap_inc(rr_idx);
        end else begin
          owner_d = rr_idx;
          cnt_d   = CW'(1);
          state_d = HOLD;
        end
      end else if (state_q == HOLD) begin
        ptr_d   = wrap_inc(owner_q);
        cnt_d   = '0;
        state_d = ARB;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= in_data_i[gnt_idx];
      index_q <= gnt_idx;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data_o  = data_q;
  assign out_index_o = index_q;
  assign out_valid_o = valid_q;

endmodule
